// File: rtl/deshift_pkg.sv
// Shared types and defaults for the deshift_rx serial receiver.
package deshift_pkg;

    localparam int              WIDTH_DEF     = 8;
    localparam logic [7:0]      SYNC_WORD_DEF = 8'hA5;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deshift_rx_if.sv
// Serial-in / word-out signal bundle between the bit source, deshift_rx and the despread sink.
interface deshift_rx_if
    import deshift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             bit_in;
    logic             bit_vld;
    logic [WIDTH-1:0] data_out;
    logic             data_vld;
    logic             locked;
    logic             sync_err;

    modport master (
        output bit_in, bit_vld,
        input  data_out, data_vld, locked, sync_err
    );

    modport slave (
        input  bit_in, bit_vld,
        output data_out, data_vld, locked, sync_err
    );
endinterface

// File: rtl/deshift_sr.sv
// MSB-first shift register with enable; flags when the incoming window equals a pattern.
module deshift_sr #(
    parameter int WIDTH = 8
) (
    input  logic             clk_1m,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] sr_next,
    output logic             match
);
    // The oldest bit falls out on the next shift and is never observed, so only WIDTH-1 bits are stored.
    logic [WIDTH-2:0] sr_q;

    assign sr_next = {sr_q, bit_in};
    assign match   = (sr_next == pattern);

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_1m) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q <= sr_next[WIDTH-2:0];
        end
    end
endmodule

// File: rtl/deshift_rx.sv
// Sync-hunting serial-to-parallel receiver; `define LOCK_FLYWHEEL_EN keeps lock across missed sync slots.
module deshift_rx
    import deshift_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int               FRAME_BYTES = 16,
    parameter int               MISS_MAX    = 2
) (
    input  logic        clk_1m,
    input  logic        rst_n,
    deshift_rx_if.slave rx
);
    localparam int         BC_W    = cnt_w(WIDTH);
    localparam logic [7:0] FRAME_N = 8'(FRAME_BYTES);

    if (FRAME_BYTES < 1 || FRAME_BYTES > 255 || MISS_MAX < 1 || MISS_MAX > 15) begin : g_param_check
        $error("deshift_rx: FRAME_BYTES or MISS_MAX out of range");
    end

    state_e           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_vld_q, data_vld_d;
    logic             locked_q;
    logic [WIDTH-1:0] sr_next;
    logic             match;
    logic             word_done;

    deshift_sr #(.WIDTH(WIDTH)) u_sr (
        .clk_1m  (clk_1m),
        .rst_n   (rst_n),
        .en      (rx.bit_vld),
        .bit_in  (rx.bit_in),
        .pattern (SYNC_WORD),
        .sr_next (sr_next),
        .match   (match)
    );

    assign word_done = (bit_cnt_q == BC_W'(WIDTH - 1));

`ifdef LOCK_FLYWHEEL_EN
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic       sync_err_q, sync_err_d;
    assign rx.sync_err = sync_err_q;
`else
    assign rx.sync_err = 1'b0;
`endif

    // NOTE: every output is given a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_out_d = data_out_q;
        data_vld_d = 1'b0;
`ifdef LOCK_FLYWHEEL_EN
        miss_cnt_d = miss_cnt_q;
        sync_err_d = 1'b0;
`endif
        if (rx.bit_vld) begin
            case (state_q)
                HUNT: begin
                    if (match) begin
                        state_d    = LOCK;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                LOCK: begin
                    if (byte_cnt_q < FRAME_N) begin
                        if (word_done) begin
                            bit_cnt_d  = '0;
                            data_out_d = sr_next;
                            data_vld_d = 1'b1;
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end else begin
`ifdef LOCK_FLYWHEEL_EN
                        if (word_done) begin
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                            if (match) begin
                                miss_cnt_d = '0;
                            end else begin
                                sync_err_d = 1'b1;
                                if (miss_cnt_q + 4'd1 == 4'(MISS_MAX)) begin
                                    state_d    = HUNT;
                                    miss_cnt_d = '0;
                                end else begin
                                    miss_cnt_d = miss_cnt_q + 4'd1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
`else
                        // Frame over: this bit is the first one the re-acquisition search sees.
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        if (!match) begin
                            state_d = HUNT;
                        end
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_1m) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            data_out_q <= '0;
            data_vld_q <= 1'b0;
            locked_q   <= 1'b0;
`ifdef LOCK_FLYWHEEL_EN
            miss_cnt_q <= '0;
            sync_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_out_q <= data_out_d;
            data_vld_q <= data_vld_d;
            locked_q   <= (state_d == LOCK);
`ifdef LOCK_FLYWHEEL_EN
            miss_cnt_q <= miss_cnt_d;
            sync_err_q <= sync_err_d;
`endif
        end
    end

    assign rx.data_out = data_out_q;
    assign rx.data_vld = data_vld_q;
    assign rx.locked   = locked_q;
endmodule

// File: tb/tb_deshift_rx.sv
// Self-checking bench for deshift_rx (FRAME_BYTES=2); expectations follow LOCK_FLYWHEEL_EN when defined.
module tb_deshift_rx;
    localparam int FRAME_BYTES = 2;
`ifdef LOCK_FLYWHEEL_EN
    localparam bit FLY = 1'b1;
`else
    localparam bit FLY = 1'b0;
`endif

    logic clk_1m = 1'b0;
    logic rst_n;
    always #5 clk_1m = ~clk_1m;

    deshift_rx_if #(.WIDTH(8)) dif ();

    deshift_rx #(
        .WIDTH       (8),
        .SYNC_WORD   (8'hA5),
        .FRAME_BYTES (FRAME_BYTES),
        .MISS_MAX    (2)
    ) dut (
        .clk_1m (clk_1m),
        .rst_n  (rst_n),
        .rx     (dif.slave)
    );

    int cyc = 0;
    always @(posedge clk_1m) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t data_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   mon_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation in value and cycle.
    always @(negedge clk_1m) begin
        if (dif.data_vld) begin
            check("vld_with_err", {31'd0, dif.sync_err}, 32'd0);
            if (data_q.size() == 0) begin
                check("data_vld_unexpected", {31'd0, dif.data_vld}, 32'd0);
            end else begin
                mon_e = data_q.pop_front();
                check("data_out", {24'd0, dif.data_out}, {24'd0, mon_e.data});
                check("data_cycle", cyc, mon_e.cyc);
            end
        end
        if (dif.sync_err) begin
            if (err_q.size() == 0) begin
                check("sync_err_unexpected", {31'd0, dif.sync_err}, 32'd0);
            end else begin
                mon_c = err_q.pop_front();
                check("sync_err_cycle", cyc, mon_c);
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk_1m);
        dif.bit_in  = b;
        dif.bit_vld = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_1m);
            dif.bit_vld = 1'b0;
        end
    endtask

    // kind: 0 = no output expected, 1 = payload word expected, 2 = sync_err expected
    task automatic send_byte(input logic [7:0] b, input int kind, input int gap_after, input int gap_len);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i == 0) begin
                if (kind == 1) data_q.push_back('{data: b, cyc: cyc + 1});
                if (kind == 2) err_q.push_back(cyc + 1);
            end
            if (8 - i == gap_after) idle(gap_len);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_1m);
        rst_n       = 1'b0;
        dif.bit_vld = 1'b0;
        dif.bit_in  = 1'b0;
        @(negedge clk_1m);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        idle(4);
        check({name, "_data_drain"}, data_q.size(), 0);
        check({name, "_err_drain"}, err_q.size(), 0);
    endtask

    typedef struct {
        string       name;
        logic [39:0] stim;
        int          n_stim;
        int          sync_idx;
        logic [15:0] exp;
        int          n_exp;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] bv;
    logic [7:0] part;
    logic       locked_fell;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic",        40'hA5_3C_C3_00_00, 3, 0, 16'h3C_C3, 2};
        vecs[1] = '{"noise",        40'h00_5A_A5_3C_C3, 5, 2, 16'h3C_C3, 2};
        vecs[2] = '{"sync_as_data", 40'hA5_A5_5A_00_00, 3, 0, 16'hA5_5A, 2};
        vecs[3] = '{"ones_zeros",   40'hA5_FF_00_00_00, 3, 0, 16'hFF_00, 2};
        vecs[4] = '{"short_frame",  40'hA5_81_00_00_00, 2, 0, 16'h81_00, 1};

        rst_n       = 1'b0;
        dif.bit_in  = 1'b0;
        dif.bit_vld = 1'b0;
        @(negedge clk_1m);
        @(negedge clk_1m);
        rst_n = 1'b1;
        check("rst_data_out", {24'd0, dif.data_out}, 32'd0);
        check("rst_data_vld", {31'd0, dif.data_vld}, 32'd0);
        check("rst_locked",   {31'd0, dif.locked},   32'd0);
        check("rst_sync_err", {31'd0, dif.sync_err}, 32'd0);

        // Table-driven single-frame streams.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n_stim; i++) begin
                bv = vecs[v].stim[39 - 8 * i -: 8];
                if (i == vecs[v].sync_idx) check({vecs[v].name, "_prelock"}, {31'd0, dif.locked}, 32'd0);
                if (i > vecs[v].sync_idx) begin
                    part = vecs[v].exp[15 - 8 * (i - vecs[v].sync_idx - 1) -: 8];
                    for (int b = 7; b >= 0; b--) begin
                        send_bit(bv[b]);
                        if (b == 0) data_q.push_back('{data: part, cyc: cyc + 1});
                    end
                end else begin
                    send_byte(bv, 0, -1, 0);
                end
            end
            drain(vecs[v].name);
            check({vecs[v].name, "_locked_end"}, {31'd0, dif.locked}, 32'd1);
        end

        // Lock rises right after the sync word's last bit and drops on the bit after the frame.
        do_reset();
        bv = 8'hA5;
        for (int b = 7; b >= 0; b--) send_bit(bv[b]);
        check("lock_before_edge", {31'd0, dif.locked}, 32'd0);
        @(posedge clk_1m); #1;
        check("lock_after_sync", {31'd0, dif.locked}, 32'd1);
        send_byte(8'h3C, 1, -1, 0);
        send_byte(8'hC3, 1, -1, 0);
        send_bit(1'b0);
        @(posedge clk_1m); #1;
        check("lock_after_frame", {31'd0, dif.locked}, {31'd0, FLY});
        drain("lock_timing");

        // bit_vld low for 3 cycles inside a payload word delays its strobe by 3 cycles.
        do_reset();
        send_byte(8'hA5, 0, -1, 0);
        send_byte(8'h11, 1, 4, 3);
        send_byte(8'h22, 1, -1, 0);
        drain("vld_gap");

        // Reset after 4 payload bits: partial word dropped, re-acquisition needs a new sync word.
        do_reset();
        send_byte(8'hA5, 0, -1, 0);
        part = 8'h11;
        for (int b = 7; b >= 4; b--) send_bit(part[b]);
        do_reset();
        check("midrst_locked", {31'd0, dif.locked}, 32'd0);
        check("midrst_data_out", {24'd0, dif.data_out}, 32'd0);
        for (int b = 3; b >= 0; b--) send_bit(part[b]);
        send_byte(8'h22, 0, -1, 0);
        idle(2);
        check("midrst_no_relock", {31'd0, dif.locked}, 32'd0);
        send_byte(8'hA5, 0, -1, 0);
        send_byte(8'h33, 1, -1, 0);
        send_byte(8'h44, 1, -1, 0);
        drain("midrst");

        // Two bad sync slots in a row: flywheel tolerates one, loses lock on the second.
        do_reset();
        send_byte(8'hA5, 0, -1, 0);
        send_byte(8'h01, 1, -1, 0);
        send_byte(8'h02, 1, -1, 0);
        send_byte(8'h00, FLY ? 2 : 0, -1, 0);
        send_byte(8'h03, FLY ? 1 : 0, -1, 0);
        send_byte(8'h04, FLY ? 1 : 0, -1, 0);
        @(posedge clk_1m); #1;
        check("miss1_locked", {31'd0, dif.locked}, {31'd0, FLY});
        send_byte(8'h00, FLY ? 2 : 0, -1, 0);
        send_byte(8'h05, 0, -1, 0);
        send_byte(8'h06, 0, -1, 0);
        drain("miss");
        check("miss2_locked", {31'd0, dif.locked}, 32'd0);

        // Good sync slot between frames: data continues; with the flywheel lock never drops.
        do_reset();
        send_byte(8'hA5, 0, -1, 0);
        send_byte(8'h01, 1, -1, 0);
        send_byte(8'h02, 1, -1, 0);
        locked_fell = 1'b0;
        bv = 8'hA5;
        for (int b = 7; b >= 0; b--) begin
            send_bit(bv[b]);
            @(posedge clk_1m); #1;
            if (!dif.locked) locked_fell = 1'b1;
        end
        send_byte(8'h03, 1, -1, 0);
        send_byte(8'h04, 1, -1, 0);
        drain("resync");
        check("resync_locked_end", {31'd0, dif.locked}, 32'd1);
        check("resync_lock_dip", {31'd0, locked_fell}, {31'd0, !FLY});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
